// File: rtl/comparator_pkg.sv
// Shared constants and status encoding for the bitwise-AND comparator.
// Consumers import this so they decode the same reset defaults as the block.
package comparator_pkg;

  localparam int unsigned CMP_WIDTH_DEF = 4;

  typedef struct packed {
    logic eq;
    logic any;
    logic none;
  } cmp_flags_t;

  // Reset state matches an all-zero AND result: no overlap, not equal.
  localparam logic       CMP_OUT_RST_BIT = 1'b0;
  localparam cmp_flags_t CMP_FLAGS_RST   = '{eq: 1'b0, any: 1'b0, none: 1'b1};

  function automatic cmp_flags_t cmp_flags(input logic eq, input logic any);
    return '{eq: eq, any: any, none: ~any};
  endfunction

endpackage

// File: rtl/comparator_if.sv
// Operand/result bundle for the comparator; master drives operands, slave returns results.
interface comparator_if
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_WIDTH_DEF
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             eq_q;
  logic             any_q;
  logic             none_q;

  modport master (output a, b, input out, out_q, eq_q, any_q, none_q);
  modport slave  (input a, b, output out, out_q, eq_q, any_q, none_q);
endinterface

// File: rtl/comparator.sv
// Bitwise-AND comparator: zero-latency a & b plus a one-cycle status register.
// Ports stay flat so legacy three-port positional instances (out, a, b) still bind.
module comparator
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = CMP_WIDTH_DEF
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q,
  output logic             eq_q,
  output logic             any_q,
  output logic             none_q
);

  logic [WIDTH-1:0] and_d;
  cmp_flags_t       flags_d;
  cmp_flags_t       flags_q;

  assign and_d   = a & b;
  assign out     = and_d;
  assign flags_d = cmp_flags(a == b, |and_d);

  // Always loading; reset wins over the sample on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= {WIDTH{CMP_OUT_RST_BIT}};
      flags_q <= CMP_FLAGS_RST;
    end else begin
      out_q   <= and_d;
      flags_q <= flags_d;
    end
  end

  assign eq_q   = flags_q.eq;
  assign any_q  = flags_q.any;
  assign none_q = flags_q.none;

endmodule

// File: tb/tb_comparator.sv
// Directed checks of the comparator at WIDTH=4 plus a random sweep at WIDTH=1 and 64.
module tb_comparator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  comparator_if #(.WIDTH(4)) bus ();

  comparator #(.WIDTH(4)) dut4 (
    .out(bus.out), .a(bus.a), .b(bus.b), .clk(clk), .rst(rst),
    .out_q(bus.out_q), .eq_q(bus.eq_q), .any_q(bus.any_q), .none_q(bus.none_q)
  );

  logic [0:0]  a1, b1, out1, out_q1;
  logic        eq_q1, any_q1, none_q1;
  logic [63:0] a64, b64, out64, out_q64;
  logic        eq_q64, any_q64, none_q64;

  comparator #(.WIDTH(1)) dut1 (
    .out(out1), .a(a1), .b(b1), .clk(clk), .rst(rst),
    .out_q(out_q1), .eq_q(eq_q1), .any_q(any_q1), .none_q(none_q1)
  );

  comparator #(.WIDTH(64)) dut64 (
    .out(out64), .a(a64), .b(b64), .clk(clk), .rst(rst),
    .out_q(out_q64), .eq_q(eq_q64), .any_q(any_q64), .none_q(none_q64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic comb_vec(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vexp);
    bus.a = va;
    bus.b = vb;
    #1;
    check($sformatf("comb %b&%b", va, vb), 64'(bus.out), 64'(vexp));
    #9;
  endtask

  task automatic check_reg4(input string tag, input logic [3:0] oq, input logic eq,
                            input logic an, input logic no);
    check({tag, " out_q"},  64'(bus.out_q),  64'(oq));
    check({tag, " eq_q"},   64'(bus.eq_q),   64'(eq));
    check({tag, " any_q"},  64'(bus.any_q),  64'(an));
    check({tag, " none_q"}, 64'(bus.none_q), 64'(no));
  endtask

  initial begin
    logic [0:0]  ea1, eb1;
    logic [63:0] ea64, eb64;

    bus.a = '0; bus.b = '0;
    a1 = '0; b1 = '0; a64 = '0; b64 = '0;

    @(posedge clk); #1;
    check_reg4("reset state", 4'b0000, 1'b0, 1'b0, 1'b1);

    comb_vec(4'b1001, 4'b0101, 4'b0001);
    comb_vec(4'b1100, 4'b1100, 4'b1100);
    comb_vec(4'b0100, 4'b1001, 4'b0000);
    comb_vec(4'b0101, 4'b0001, 4'b0001);
    comb_vec(4'b0010, 4'b0111, 4'b0010);
    comb_vec(4'b1111, 4'b0000, 4'b0000);
    comb_vec(4'b0000, 4'b1111, 4'b0000);
    comb_vec(4'b0011, 4'b0011, 4'b0011);
    comb_vec(4'b1001, 4'b0011, 4'b0001);
    comb_vec(4'b0110, 4'b1000, 4'b0000);

    // Reset held across an edge with all-ones operands
    @(negedge clk); bus.a = 4'b1111; bus.b = 4'b1111; rst = 1'b1;
    @(posedge clk); #1;
    check_reg4("rst hold", 4'b0000, 1'b0, 1'b0, 1'b1);
    check("rst comb out", 64'(bus.out), 64'h0000_0000_0000_000F);

    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_reg4("post rst", 4'b1111, 1'b1, 1'b1, 1'b0);

    @(negedge clk); bus.a = 4'b1100; bus.b = 4'b1100;
    @(posedge clk); #1;
    check_reg4("reg C&C", 4'b1100, 1'b1, 1'b1, 1'b0);

    @(negedge clk); bus.a = 4'b0100; bus.b = 4'b1001;
    @(posedge clk); #1;
    check_reg4("reg 4&9", 4'b0000, 1'b0, 1'b0, 1'b1);

    // Mid-cycle operand changes touch only the combinational output
    @(negedge clk); bus.a = 4'b0011; bus.b = 4'b0011; #1;
    check("mid out 3&3", 64'(bus.out), 64'h3);
    check_reg4("mid hold1", 4'b0000, 1'b0, 1'b0, 1'b1);
    bus.a = 4'b0001; #1;
    check("mid out 1&3", 64'(bus.out), 64'h1);
    check_reg4("mid hold2", 4'b0000, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_reg4("mid load", 4'b0001, 1'b0, 1'b1, 1'b0);

    @(negedge clk); bus.a = 4'b1010; bus.b = 4'b1110; rst = 1'b1;
    @(posedge clk); #1;
    check_reg4("rst midstream", 4'b0000, 1'b0, 1'b0, 1'b1);
    check("rst mid out", 64'(bus.out), 64'hA);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      a1 = 1'($urandom); b1 = 1'($urandom);
      // Bias toward equal operands now and then so eq_q sees both values
      a64 = {$urandom, $urandom};
      b64 = (i % 8 == 0) ? a64 : {$urandom, $urandom};
      ea1 = a1; eb1 = b1; ea64 = a64; eb64 = b64;
      #1;
      check("w1 out",  64'(out1), 64'(ea1 & eb1));
      check("w64 out", out64,     ea64 & eb64);
      @(posedge clk); #1;
      check("w1 out_q",   64'(out_q1),   64'(ea1 & eb1));
      check("w1 eq_q",    64'(eq_q1),    64'(ea1 == eb1));
      check("w1 any_q",   64'(any_q1),   64'(|(ea1 & eb1)));
      check("w1 none_q",  64'(none_q1),  64'(~|(ea1 & eb1)));
      check("w64 out_q",  out_q64,       ea64 & eb64);
      check("w64 eq_q",   64'(eq_q64),   64'(ea64 == eb64));
      check("w64 any_q",  64'(any_q64),  64'(|(ea64 & eb64)));
      check("w64 none_q", 64'(none_q64), 64'(~|(ea64 & eb64)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/comparator.md
# comparator

Bitwise-AND comparator on two WIDTH-bit operands. A combinational output gives out = a & b with zero latency, usable without a running clock. A registered status stage adds a one-cycle-delayed copy of the AND result plus equality and overlap flags. It is a leaf datapath block feeding mask/match logic in the project datapath.

## Interface

Parameters:
- WIDTH, default 4: operand and result width; legal range 1–64.

Ports. Positional declaration order is out, a, b, clk, rst, so three-port positional instantiations stay valid; in a clockless context, tie clk and rst to 0.
- clk, input, 1: single clock; all registers update on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- out, output, WIDTH: combinational a & b.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- out_q, output, WIDTH: registered a & b.
- eq_q, output, 1: registered (a == b).
- any_q, output, 1: registered |(a & b); at least one common set bit.
- none_q, output, 1: registered ~|(a & b); always the complement of any_q.

## Operation

- out[i] = a[i] & b[i] for every bit i.
  - Purely combinational; no state.
  - Changes in the same delta as a or b.
  - Not affected by rst or clk.
- Status register (out_q, eq_q, any_q, none_q):
  - Loaded every rising clk edge from the current a and b when rst = 0.
  - No enable; the register is always loading.
- Reset behaviour:
  - rst = 1 at a rising edge: out_q = 0, eq_q = 0, any_q = 0, none_q = 1. This is consistent with an all-zero AND result.
  - rst overrides the load on the same edge.
  - Reset mid-stream discards the sampled values.
- Width rules:
  - No carries, no sign interpretation; operands are unsigned bit vectors.
  - eq_q compares all WIDTH bits.
- X handling: unknown operand bits propagate per standard AND semantics. A 0 on either input forces a 0 result bit.

## Timing

- out: 0-cycle latency.
- Registered outputs: 1-cycle latency. Values sampled at edge N appear after edge N and hold until edge N+1.
- Reset:
  - Takes effect only on a clock edge.
  - The first valid registered result appears one edge after rst deasserts.
- Operands changing between edges affect only out, never the registered outputs.
- No handshake; a new operand pair is accepted every cycle.

## Structure

- Single module, no sub-modules.
- Shared package holds:
  - the default width constant (4);
  - the reset values of the status fields, so consumers decode the same defaults.
- The status bundle may be declared as a packed struct in the package. It stays flattened at the ports.

## Test plan

All combinational checks use WIDTH = 4 and hold 10 time units per vector.
- Combinational vectors:
  - a=1001, b=0101 -> out=0001
  - a=1100, b=1100 -> out=1100
  - a=0100, b=1001 -> out=0000
  - a=0101, b=0001 -> out=0001
  - a=0010, b=0111 -> out=0010
- Boundary vectors:
  - a=1111, b=0000 -> out=0000
  - a=0000, b=1111 -> out=0000
  - a=0011, b=0011 -> out=0011
  - a=1001, b=0011 -> out=0001
  - a=0110, b=1000 -> out=0000
- Registered path, clock running:
  - a=1100, b=1100 -> after the next edge: out_q=1100, eq_q=1, any_q=1, none_q=0.
  - a=0100, b=1001 -> after the next edge: out_q=0000, eq_q=0, any_q=0, none_q=1.
- Reset:
  - Hold rst=1 across an edge with a=1111, b=1111 -> out_q=0000, eq_q=0, any_q=0, none_q=1, while out=1111 combinationally.
  - Deassert rst -> the next edge loads out_q=1111, eq_q=1.
- Between-edge change: alter a mid-cycle -> out updates immediately; registered outputs stay unchanged until the next edge.
- Parameter sweep: WIDTH=1 and WIDTH=64, random operands, 1000 cycles -> out == a & b every cycle; registered outputs match the values sampled on the previous edge.
